// File: rtl/mx_mdio_master.sv
// Clause-22 MDIO management master: serialises one register access at a time
// onto MDC/MDIO and returns read data plus a no-response flag.
module mx_mdio_master #(
  parameter int unsigned CLK_DIV     = 25,
  parameter bit          PREAMBLE_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rd_i,
  input  logic [4:0]  cmd_phy_addr_i,
  input  logic [4:0]  cmd_reg_addr_i,
  input  logic [15:0] cmd_wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic        rd_err_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  localparam int unsigned DIV_W    = 8;
  localparam int unsigned BIT_W    = 6;
  localparam int unsigned FRAME_W  = 64;
  localparam int unsigned RX_W     = 17;
  localparam int unsigned N_BITS   = PREAMBLE_EN ? 64 : 32;
  localparam int unsigned PRE_BITS = PREAMBLE_EN ? 32 : 0;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS - 1);
  // First turnaround bit: on reads the master releases the bus from here on
  localparam logic [BIT_W-1:0] TA_BIT   = BIT_W'(PRE_BITS + 14);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [RX_W-1:0]      rx_q, rx_d;
  logic [1:0]           sync_q, sync_d;
  logic                 rd_q, rd_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 rd_err_q, rd_err_d;
  logic                 mdc_q, mdc_d;
  logic                 mdio_q, mdio_d;
  logic                 oe_q, oe_d;

  logic [31:0]          payload_c;
  logic [FRAME_W-1:0]   frame_c;

  // Frame image for the command currently on the inputs
  always_comb begin
    payload_c = {2'b01,
                 cmd_rd_i ? 2'b10 : 2'b01,
                 cmd_phy_addr_i,
                 cmd_reg_addr_i,
                 cmd_rd_i ? 2'b11 : 2'b10,
                 cmd_rd_i ? 16'hFFFF : cmd_wdata_i};
    if (PREAMBLE_EN) begin
      frame_c = {32'hFFFF_FFFF, payload_c};
    end else begin
      frame_c = {payload_c, 32'h0000_0000};
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    rx_d     = rx_q;
    sync_d   = {sync_q[0], mdio_i};
    rd_d     = rd_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    rd_err_d = rd_err_q;
    mdc_d    = mdc_q;
    mdio_d   = mdio_q;
    oe_d     = oe_q;

    case (state_q)
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!mdc_q) begin
            // Rising MDC edge: sample the synchronised pad
            mdc_d = 1'b1;
            rx_d  = {rx_q[RX_W-2:0], sync_q[1]};
          end else if (bit_q == BIT_LAST) begin
            state_d = ST_DONE;
            mdc_d   = 1'b0;
            mdio_d  = 1'b1;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ready_d = 1'b1;
            if (rd_q) begin
              rdata_d  = rx_q[15:0];
              rd_err_d = rx_q[16];
            end
          end else begin
            mdc_d   = 1'b0;
            bit_d   = bit_q + BIT_W'(1);
            frame_d = frame_q << 1;
            mdio_d  = frame_q[FRAME_W-2];
            oe_d    = !rd_q || (bit_d < TA_BIT);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        // IDLE and the single DONE cycle both accept a new command
        state_d = ST_IDLE;
        if (cmd_valid_i) begin
          state_d = ST_SHIFT;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          rd_d    = cmd_rd_i;
          frame_d = frame_c;
          mdc_d   = 1'b0;
          mdio_d  = frame_c[FRAME_W-1];
          oe_d    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      rx_q     <= '0;
      sync_q   <= 2'b11;
      rd_q     <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      rd_err_q <= 1'b0;
      mdc_q    <= 1'b0;
      mdio_q   <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      rx_q     <= rx_d;
      sync_q   <= sync_d;
      rd_q     <= rd_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      rd_err_q <= rd_err_d;
      mdc_q    <= mdc_d;
      mdio_q   <= mdio_d;
      oe_q     <= oe_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign rd_err_o    = rd_err_q;
  assign mdc_o       = mdc_q;
  assign mdio_o      = mdio_q;
  assign mdio_oe_o   = oe_q;

endmodule

// File: tb/tb_mx_mdio_master.sv
// Scoreboard bench for mx_mdio_master: one preamble instance (CLK_DIV=3) and
// one preamble-less instance (CLK_DIV=4), each with a behavioural PHY.
module tb_mx_mdio_master;

  localparam int unsigned DIV_A = 3;
  localparam int unsigned DIV_B = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  valid, ready, rd, busy, done, err, mdc, mdio_o, oe;
  logic [4:0]  phy [2];
  logic [4:0]  rg [2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];
  logic        phy_val [2];
  logic        mdio_in_a, mdio_in_b;

  assign mdio_in_a = oe[0] ? mdio_o[0] : phy_val[0];
  assign mdio_in_b = oe[1] ? mdio_o[1] : phy_val[1];

  mx_mdio_master #(.CLK_DIV(DIV_A), .PREAMBLE_EN(1'b1)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(valid[0]), .cmd_ready_o(ready[0]), .cmd_rd_i(rd[0]),
    .cmd_phy_addr_i(phy[0]), .cmd_reg_addr_i(rg[0]), .cmd_wdata_i(wdata[0]),
    .busy_o(busy[0]), .done_o(done[0]), .rdata_o(rdata[0]), .rd_err_o(err[0]),
    .mdc_o(mdc[0]), .mdio_o(mdio_o[0]), .mdio_oe_o(oe[0]), .mdio_i(mdio_in_a)
  );

  mx_mdio_master #(.CLK_DIV(DIV_B), .PREAMBLE_EN(1'b0)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(valid[1]), .cmd_ready_o(ready[1]), .cmd_rd_i(rd[1]),
    .cmd_phy_addr_i(phy[1]), .cmd_reg_addr_i(rg[1]), .cmd_wdata_i(wdata[1]),
    .busy_o(busy[1]), .done_o(done[1]), .rdata_o(rdata[1]), .rd_err_o(err[1]),
    .mdc_o(mdc[1]), .mdio_o(mdio_o[1]), .mdio_oe_o(oe[1]), .mdio_i(mdio_in_b)
  );

  typedef struct {
    int          g;
    logic [63:0] frame;
    logic [63:0] oe;
    logic [15:0] rdata;
    logic        err;
    longint      done_cyc;
    int          busy_cycles;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;

  logic        phy_en = 1'b0;
  logic [15:0] phy_data = 16'h0000;
  logic [15:0] m_rdata [2];
  logic        m_err [2];

  int          bitn [2];
  logic [63:0] cap_bits [2];
  logic [63:0] cap_oe [2];
  int          busy_cnt [2];
  logic        mdc_prev [2];
  logic        first_bit [2];
  int          done_cnt [2];
  int          chain_cnt [2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int g);
    exp_t        e;
    int unsigned n, pre, div;
    logic [63:0] ones;
    logic [31:0] payload;
    ones    = '1;
    n       = (g == 0) ? 64 : 32;
    pre     = (g == 0) ? 32 : 0;
    div     = (g == 0) ? DIV_A : DIV_B;
    payload = {2'b01, rd[g] ? 2'b10 : 2'b01, phy[g], rg[g], 2'b10, wdata[g]};
    e.g     = g;
    e.frame = (g == 0) ? {32'hFFFF_FFFF, payload} : {payload, 32'h0};
    e.oe    = rd[g] ? ~(ones >> (pre + 14)) : ~(ones >> n);
    if (rd[g]) begin
      m_rdata[g] = phy_en ? phy_data : 16'hFFFF;
      m_err[g]   = !phy_en;
    end
    e.rdata       = m_rdata[g];
    e.err         = m_err[g];
    e.done_cyc    = cyc + 1 + 2 * n * div;
    e.busy_cycles = int'(2 * n * div);
    sb_q.push_back(e);
  endtask

  task automatic check_done(input int g);
    exp_t e;
    check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val("sb_port", 64'(g), 64'(e.g));
      check_val("done_cycle", 64'(cyc), 64'(e.done_cyc));
      check_val("frame_bits", cap_bits[g] & e.oe, e.frame & e.oe);
      check_val("frame_oe", cap_oe[g], e.oe);
      check_val("rdata", 64'(rdata[g]), 64'(e.rdata));
      check_val("rd_err", 64'(err[g]), 64'(e.err));
      check_val("busy_cycles", 64'(busy_cnt[g]), 64'(e.busy_cycles));
      check_val("done_ready_busy", 64'({ready[g], busy[g]}), 64'b10);
    end
  endtask

  // Bus monitor and PHY model; PHY updates its drive just after each MDC rise
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        bitn[g] = 0; cap_bits[g] = '0; cap_oe[g] = '0; busy_cnt[g] = 0;
        mdc_prev[g] = 1'b0; phy_val[g] = 1'b1;
      end else begin
        if (valid[g] && ready[g]) begin
          if (done[g]) chain_cnt[g]++;
          push_exp(g);
        end
        if (busy[g]) busy_cnt[g]++;
        if (mdc[g] && !mdc_prev[g]) begin
          int p;
          if (bitn[g] == 0) first_bit[g] = mdio_o[g];
          if (bitn[g] < 64) begin
            cap_bits[g][63 - bitn[g]] = mdio_o[g];
            cap_oe[g][63 - bitn[g]]   = oe[g];
          end
          bitn[g]++;
          p = bitn[g] - ((g == 0) ? 32 : 0);
          if (!phy_en)                 phy_val[g] = 1'b1;
          else if (p == 15)            phy_val[g] = 1'b0;
          else if (p >= 16 && p <= 31) phy_val[g] = phy_data[31 - p];
          else                         phy_val[g] = 1'b1;
        end
        mdc_prev[g] = mdc[g];
        if (done[g]) begin
          done_cnt[g]++;
          check_done(g);
          bitn[g] = 0; cap_bits[g] = '0; cap_oe[g] = '0; busy_cnt[g] = 0;
          phy_val[g] = 1'b1;
        end
      end
    end
  end

  task automatic send(input int g, input logic r, input logic [4:0] pa,
                      input logic [4:0] ra, input logic [15:0] wd);
    int n;
    n = 0;
    @(posedge clk); #1;
    rd[g] = r; phy[g] = pa; rg[g] = ra; wdata[g] = wd; valid[g] = 1'b1;
    do begin @(negedge clk); n++; end while (!ready[g] && n < 5000);
    check_val("accept_wait", 64'(ready[g]), 64'd1);
    @(posedge clk); #1 valid[g] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    check_val("idle_wait", 64'(sb_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, c0, n;
    rst = 1'b1; valid = '0; rd = '0;
    for (int g = 0; g < 2; g++) begin
      phy[g] = '0; rg[g] = '0; wdata[g] = '0; m_rdata[g] = '0; m_err[g] = 1'b0;
      done_cnt[g] = 0; chain_cnt[g] = 0; first_bit[g] = 1'b1; phy_val[g] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check_val("rst_ready", 64'(ready), 64'b11);
    check_val("rst_busy", 64'(busy), 64'b00);
    check_val("rst_done", 64'(done), 64'b00);
    check_val("rst_rdata", 64'(rdata[0]), 64'h0);
    check_val("rst_rd_err", 64'(err), 64'b00);
    check_val("rst_mdc", 64'(mdc), 64'b00);
    check_val("rst_mdio", 64'(mdio_o), 64'b11);
    check_val("rst_oe", 64'(oe), 64'b00);
    @(posedge clk); #1 rst = 1'b0;

    // Write 0x1140 to PHY 1 reg 0 with preamble
    send(0, 1'b0, 5'h01, 5'h00, 16'h1140);
    wait_idle();

    // Read with responding PHY
    phy_en = 1'b1; phy_data = 16'hBEEF;
    send(0, 1'b1, 5'h02, 5'h02, 16'h0000);
    wait_idle();

    // Read with no PHY, then a write that must not disturb read results
    phy_en = 1'b0;
    send(0, 1'b1, 5'h1F, 5'h11, 16'h0000);
    wait_idle();
    send(0, 1'b0, 5'h04, 5'h09, 16'h0F0F);
    wait_idle();
    check_val("hold_rdata", 64'(rdata[0]), 64'hFFFF);
    check_val("hold_rd_err", 64'(err[0]), 64'd1);

    // Two commands with valid held high; extra requests while busy are ignored
    d0 = done_cnt[0]; c0 = chain_cnt[0];
    phy_en = 1'b1; phy_data = 16'h1234;
    @(posedge clk); #1;
    rd[0] = 1'b0; phy[0] = 5'h03; rg[0] = 5'h04; wdata[0] = 16'hA5A5; valid[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!ready[0] && n < 5000);
      check_val("b2b_accept_wait", 64'(ready[0]), 64'd1);
      @(posedge clk); #1;
      rd[0] = 1'b1; phy[0] = 5'h06; rg[0] = 5'h1E; wdata[0] = 16'h0000;
    end
    valid[0] = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check_val("b2b_done_pulses", 64'(done_cnt[0] - d0), 64'd2);
    check_val("b2b_chained", 64'(chain_cnt[0] - c0), 64'd1);

    // Reset during bit 20 of a write
    d0 = done_cnt[0];
    send(0, 1'b0, 5'h01, 5'h10, 16'hCAFE);
    n = 0;
    while (bitn[0] < 20 && n < 5000) begin @(negedge clk); n++; end
    check_val("bit20_wait", 64'(bitn[0] >= 20), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("abort_mdc", 64'(mdc[0]), 64'd0);
    check_val("abort_oe", 64'(oe[0]), 64'd0);
    check_val("abort_ready", 64'(ready[0]), 64'd1);
    check_val("abort_busy", 64'(busy[0]), 64'd0);
    check_val("abort_mdio", 64'(mdio_o[0]), 64'd1);
    sb_q.delete();
    m_rdata[0] = '0; m_err[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("abort_no_done", 64'(done_cnt[0] - d0), 64'd0);
    check_val("abort_rdata_rst", 64'(rdata[0]), 64'h0);
    phy_data = 16'h5A3C;
    send(0, 1'b1, 5'h02, 5'h03, 16'h0000);
    wait_idle();

    // Preamble-less instance, CLK_DIV=4 read
    phy_data = 16'hC3A5;
    send(1, 1'b1, 5'h07, 5'h15, 16'h0000);
    wait_idle();
    check_val("np_first_bit_st0", 64'(first_bit[1]), 64'd0);
    check_val("np_rdata", 64'(rdata[1]), 64'hC3A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mx_mdio_master.md
# mx_mdio_master

Clause-22 MDIO management master for the MX 1G PHYs. It sits directly downstream of the PHY CSR-to-interface stage: it takes one register access command at a time (read or write, PHY address, register address, write data) and serialises it onto MDC/MDIO. For reads it returns the 16-bit data and a no-response flag. One instance is used per port.

## Interface
- `CLK_DIV`, default 25: MDC half-period in `clk_i` cycles; legal range 3..255. MDC = f(clk_i) / (2·CLK_DIV).
- `PREAMBLE_EN`, default 1: 1 sends the 32-bit all-ones preamble; 0 suppresses it (preamble-less PHYs).
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  engine idle; command accepted on `cmd_valid_i & cmd_ready_o`.
- `cmd_rd_i`  in  1  1 = read, 0 = write.
- `cmd_phy_addr_i`  in  5  PHYAD.
- `cmd_reg_addr_i`  in  5  REGAD.
- `cmd_wdata_i`  in  16  write data (ignored for reads).
- `busy_o`  out  1  frame in progress.
- `done_o`  out  1  one-cycle pulse at end of any frame.
- `rdata_o`  out  16  read data; held until next read completes.
- `rd_err_o`  out  1  valid with `done_o` for reads: PHY did not drive TA low; held like `rdata_o`.
- `mdc_o`  out  1  management clock.
- `mdio_o`  out  1  MDIO output value.
- `mdio_oe_o`  out  1  MDIO output enable (1 = drive).
- `mdio_i`  in  1  MDIO pad input (asynchronous).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `cmd_ready_o`=1, `mdc_o`=0, `mdio_oe_o`=0. On acceptance, latch the fields, build the frame and go to SHIFT.
- Frame layout, MSB first:
  - [32×1 if PREAMBLE_EN]
  - ST=01
  - OP=01 for a write, 10 for a read
  - PHYAD[4:0], REGAD[4:0]
  - TA
  - DATA[15:0]
- Frame length N is 64 bits, or 32 bits when PREAMBLE_EN=0.
- Write: TA=10; all bits are driven, with `mdio_oe_o`=1 for the whole frame.
- Read: `mdio_oe_o`=1 through REGAD[0]. It is 0 from the first TA bit to the end of the frame.
  - The PHY's second TA bit is sampled: if it is 1, set `rd_err_o`=1.
  - 16 data bits are sampled MSB first into `rdata_o`.
  - With no PHY (bus pulled high), `rdata_o`=16'hFFFF.
- `mdio_i` passes through a 2-flop synchroniser before sampling. This is why CLK_DIV≥3.
- Bit counter: 6 bits, counts 0..N-1. The half-period divider counts 0..CLK_DIV-1.
- DONE: lasts one cycle. In it: `done_o`=1, `busy_o`=0, `cmd_ready_o`=1, and `rdata_o`/`rd_err_o` update for reads. The FSM returns to IDLE.
  - A command presented in the DONE cycle is accepted there. The next frame then starts with no extra gap.
- Writes leave `rdata_o`/`rd_err_o` unchanged.
- `cmd_valid_i` while busy: ignored, not queued. Field inputs are don't-care except in the acceptance cycle.

## Timing
- Acceptance at cycle T. Bit k's low phase starts at T+1+2k·CLK_DIV:
  - `mdc_o`=0 and `mdio_o`/`mdio_oe_o` update in that cycle, for CLK_DIV cycles;
  - then `mdc_o`=1 for CLK_DIV cycles.
- Read sample point: the synchronised `mdio_i` is captured in the cycle where `mdc_o` goes 0→1.
- DONE (`done_o`=1) occurs at cycle T+1+2N·CLK_DIV. That is 3201 cycles after T for N=64, CLK_DIV=25.
- `busy_o`=1 from T+1 through T+2N·CLK_DIV.
- Outputs are never glitched; all outputs are registered.
- Reset values: `cmd_ready_o`=1, `busy_o`=0, `done_o`=0, `rdata_o`=0, `rd_err_o`=0, `mdc_o`=0, `mdio_o`=1, `mdio_oe_o`=0. FSM=IDLE, counters=0.
- Reset mid-frame aborts immediately (asynchronous) to the reset values. No `done_o` is produced. The first command after release is accepted normally.

## Test plan
- Write PHYAD=5'h01, REGAD=5'h00, data 16'h1140, CLK_DIV=3, PREAMBLE_EN=1 -> 64 bits captured on MDC rising edges:
  - 32 ones, then 01 01 00001 00000 10 0001000101000000;
  - `mdio_oe_o`=1 throughout;
  - `done_o` at T+385.
- Read PHYAD=5'h02, REGAD=5'h02, with a PHY model driving TA=0 and data 16'hBEEF -> `rdata_o`=16'hBEEF and `rd_err_o`=0 at `done_o`; `mdio_oe_o`=0 from bit 46 onward.
- Read with no PHY (pull-up, `mdio_i`=1) -> `rdata_o`=16'hFFFF, `rd_err_o`=1; a following write leaves both unchanged.
- `cmd_valid_i` held high continuously with 2 commands -> the second is accepted in the DONE cycle of the first; extra commands while busy are ignored; exactly 2 `done_o` pulses.
- `rst_i` asserted at bit 20 of a write -> immediately `mdc_o`=0, `mdio_oe_o`=0, `cmd_ready_o`=1, no `done_o`; the next read completes correctly.
- PREAMBLE_EN=0, CLK_DIV=4, read -> 32-bit frame, `done_o` at T+257, first MDC edge carries ST bit 0.
